// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe engine.
// Squares are numbered 1..9; board bit k-1 represents square k.
package ttt_pkg;

  typedef enum logic [2:0] {
    START   = 3'd0,
    H_WAIT  = 3'd1,
    H_INV   = 3'd2,
    H_REL   = 3'd3,
    C_MOVE  = 3'd4,
    C_CHK   = 3'd5,
    OVER    = 3'd6,
    NG_WAIT = 3'd7
  } state_t;

  typedef logic [3:0] square_t;

  localparam logic [8:0] WIN_LINES [8] = '{
    9'b000000111, 9'b000111000, 9'b111000000,
    9'b001001001, 9'b010010010, 9'b100100100,
    9'b100010001, 9'b001010100
  };

  localparam square_t CORNER_ORDER [4] = '{4'd1, 4'd3, 4'd7, 4'd9};
  localparam square_t EDGE_ORDER   [4] = '{4'd2, 4'd4, 4'd6, 4'd8};

  // One-hot board mask for a square; out-of-range squares map to no bit.
  function automatic logic [8:0] sq_mask(input square_t s);
    logic [8:0] m;
    m = '0;
    if (s >= 4'd1 && s <= 4'd9) m = 9'b1 << (s - 4'd1);
    return m;
  endfunction

  function automatic logic has_line(input logic [8:0] b);
    logic r;
    r = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((b & WIN_LINES[l]) == WIN_LINES[l]) r = 1'b1;
    end
    return r;
  endfunction

  // Lowest-numbered square present in the mask; 0 if empty.
  function automatic square_t lowest_square(input logic [8:0] m);
    square_t r;
    r = '0;
    for (int i = 8; i >= 0; i--) begin
      if (m[i]) r = square_t'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/ttt_strategy.sv
// Combinational move chooser: win, block, centre, corner, edge;
// ties resolve to the lowest square number.
module ttt_strategy
  import ttt_pkg::*;
(
  input  logic [8:0] c_board_i,
  input  logic [8:0] h_board_i,
  output square_t    square_o
);

  logic [8:0] occ;
  logic [8:0] c_win;
  logic [8:0] h_blk;
  logic [8:0] corner_free;
  logic [8:0] edge_free;

  always_comb begin
    occ         = c_board_i | h_board_i;
    c_win       = '0;
    h_blk       = '0;
    corner_free = '0;
    edge_free   = '0;
    for (int l = 0; l < 8; l++) begin
      if ($countones(c_board_i & WIN_LINES[l]) == 2 && (h_board_i & WIN_LINES[l]) == '0)
        c_win = c_win | (WIN_LINES[l] & ~occ);
      if ($countones(h_board_i & WIN_LINES[l]) == 2 && (c_board_i & WIN_LINES[l]) == '0)
        h_blk = h_blk | (WIN_LINES[l] & ~occ);
    end
    for (int i = 0; i < 4; i++) begin
      corner_free = corner_free | (sq_mask(CORNER_ORDER[i]) & ~occ);
      edge_free   = edge_free   | (sq_mask(EDGE_ORDER[i])   & ~occ);
    end

    if (|c_win)           square_o = lowest_square(c_win);
    else if (|h_blk)      square_o = lowest_square(h_blk);
    else if (!occ[4])     square_o = 4'd5;
    else if (|corner_free) square_o = lowest_square(corner_free);
    else                  square_o = lowest_square(edge_free);
  end

endmodule

// File: rtl/ttt_engine.sv
// Tic-tac-toe game engine: board registers, move validation, history
// displays and outcome flags around a rule-based computer player.
module ttt_engine
  import ttt_pkg::*;
#(
  parameter int HIST = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter_L,
  input  logic              newGame_L,
  input  logic [3:0]        hMove,
  input  logic              humanFirst,
  output logic [3:0]        cMove,
  output logic              win,
  output logic              lose,
  output logic              draw,
  output logic              invalid,
  output logic [8:0]        cBoard,
  output logic [8:0]        hBoard,
  output logic [HIST*4-1:0] cHist,
  output logic [HIST*4-1:0] hHist
);

  localparam int CW = $clog2(HIST + 1);

  state_t            state_q;
  logic [8:0]        c_board_q, h_board_q;
  square_t           c_move_q;
  logic              win_q, lose_q, draw_q, invalid_q;
  logic [HIST*4-1:0] c_hist_q, h_hist_q;
  logic [CW-1:0]     c_cnt_q, h_cnt_q;

  logic [8:0] occ;
  logic [8:0] h_mask;
  logic       h_legal;
  square_t    strat_sq;
  logic       board_full;

  assign occ        = c_board_q | h_board_q;
  assign h_mask     = sq_mask(hMove);
  assign h_legal    = (|h_mask) && ((h_mask & occ) == '0);
  assign board_full = &occ;

  ttt_strategy u_strategy (
    .c_board_i (c_board_q),
    .h_board_i (h_board_q),
    .square_o  (strat_sq)
  );

  // Writes the next free slot (slot 0 = MS nibble); a full history is left as is.
  function automatic logic [HIST*4-1:0] hist_push(input logic [HIST*4-1:0] h,
                                                   input logic [CW-1:0] cnt,
                                                   input square_t sq);
    logic [HIST*4-1:0] r;
    r = h;
    for (int i = 0; i < HIST; i++) begin
      if (cnt == CW'(i)) r[(HIST-1-i)*4 +: 4] = sq;
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= START;
      c_board_q <= '0;
      h_board_q <= '0;
      c_move_q  <= '0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      draw_q    <= 1'b0;
      invalid_q <= 1'b0;
      c_hist_q  <= '0;
      h_hist_q  <= '0;
      c_cnt_q   <= '0;
      h_cnt_q   <= '0;
    end else if (!newGame_L && state_q != START && state_q != NG_WAIT) begin
      state_q <= NG_WAIT;
    end else begin
      case (state_q)
        START: begin
          c_board_q <= '0;
          h_board_q <= '0;
          c_move_q  <= '0;
          win_q     <= 1'b0;
          lose_q    <= 1'b0;
          draw_q    <= 1'b0;
          invalid_q <= 1'b0;
          c_hist_q  <= '0;
          h_hist_q  <= '0;
          c_cnt_q   <= '0;
          h_cnt_q   <= '0;
          state_q   <= humanFirst ? H_WAIT : C_MOVE;
        end
        H_WAIT: begin
          if (!enter_L) begin
            if (h_legal) begin
              h_board_q <= h_board_q | h_mask;
              h_hist_q  <= hist_push(h_hist_q, h_cnt_q, hMove);
              if (h_cnt_q != CW'(HIST)) h_cnt_q <= h_cnt_q + 1'b1;
              state_q   <= H_REL;
            end else begin
              invalid_q <= 1'b1;
              state_q   <= H_INV;
            end
          end
        end
        H_INV: begin
          if (enter_L) begin
            invalid_q <= 1'b0;
            state_q   <= H_WAIT;
          end
        end
        H_REL: begin
          if (enter_L) begin
            if (has_line(h_board_q)) begin
              lose_q  <= 1'b1;
              state_q <= OVER;
            end else if (board_full) begin
              draw_q  <= 1'b1;
              state_q <= OVER;
            end else begin
              state_q <= C_MOVE;
            end
          end
        end
        C_MOVE: begin
          c_board_q <= c_board_q | sq_mask(strat_sq);
          c_move_q  <= strat_sq;
          c_hist_q  <= hist_push(c_hist_q, c_cnt_q, strat_sq);
          if (c_cnt_q != CW'(HIST)) c_cnt_q <= c_cnt_q + 1'b1;
          state_q   <= C_CHK;
        end
        C_CHK: begin
          if (has_line(c_board_q)) begin
            win_q   <= 1'b1;
            state_q <= OVER;
          end else if (board_full) begin
            draw_q  <= 1'b1;
            state_q <= OVER;
          end else begin
            state_q <= H_WAIT;
          end
        end
        OVER: state_q <= OVER;
        NG_WAIT: begin
          if (newGame_L) state_q <= START;
        end
        default: state_q <= START;
      endcase
    end
  end

  assign cMove   = c_move_q;
  assign win     = win_q;
  assign lose    = lose_q;
  assign draw    = draw_q;
  assign invalid = invalid_q;
  assign cBoard  = c_board_q;
  assign hBoard  = h_board_q;
  assign cHist   = c_hist_q;
  assign hHist   = h_hist_q;

endmodule
